// File: rtl/traffic_phase_scheduler.sv
// Traffic phase scheduler: debounces four phase requests, ages them and offers one
// phase at a time to the light controller, with emergency preemption and starvation relief.
//   state  | meaning
//   IDLE   | nothing pending, no preemption outstanding
//   ARB    | one-cycle arbitration, registers the chosen phase into grant_phase
//   OFFER  | grant_valid held with a stable grant_phase until grant_ready
//   ACTIVE | granted phase running on the lights, waiting for phase_done
module traffic_phase_scheduler #(
    parameter int DEBOUNCE   = 3,
    parameter int STARVE_MAX = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_str_sensor,
    input  logic       ew_left_sensor,
    input  logic       ns_sensor,
    input  logic       ped_button,
    input  logic       preempt,
    input  logic [1:0] preempt_phase,
    output logic       grant_valid,
    output logic [1:0] grant_phase,
    input  logic       grant_ready,
    input  logic       phase_done,
    output logic       abort,
    output logic [3:0] pending,
    output logic       busy
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [1:0] {IDLE, ARB, OFFER, ACTIVE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      raw;
    logic [3:0]      filt;
    logic [3:0]      starved;
    logic [CW-1:0]   db_cnt [4];
    logic [7:0]      age [4];
    logic            preempt_pend;
    logic [1:0]      preempt_id;
    logic [1:0]      last_granted;
    logic [1:0]      arb_phase;
    logic [1:0]      rr_idx;
    logic            arb_found;
    logic            arb_pre;
    logic            grant_pre;
    logic            abort_sent;
    logic            abort_nx;
    logic            accept;
    logic            go_arb;
    logic            in_grant;

    assign raw         = {ped_button, ns_sensor, ew_left_sensor, ew_str_sensor};
    assign accept      = (state == OFFER) && grant_ready;
    assign go_arb      = (|pending) || preempt_pend;
    assign in_grant    = (state == OFFER) || (state == ACTIVE);
    assign grant_valid = (state == OFFER);
    assign busy        = (state != IDLE);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            starved[i] = (int'(age[i]) >= STARVE_MAX);
        end
    end

    // Priority: preemption, then lowest starved index, then round-robin after last_granted.
    always_comb begin
        arb_found = 1'b0;
        arb_phase = 2'd0;
        arb_pre   = 1'b0;
        rr_idx    = 2'd0;
        if (preempt_pend) begin
            arb_found = 1'b1;
            arb_phase = preempt_id;
            arb_pre   = 1'b1;
        end else if (|starved) begin
            arb_found = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                if (starved[i]) arb_phase = 2'(i);
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                rr_idx = last_granted + 2'd1 + 2'(k);
                if (pending[rr_idx]) begin
                    arb_found = 1'b1;
                    arb_phase = rr_idx;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        abort_nx = (state == ACTIVE) && preempt_pend && (preempt_id != grant_phase)
                   && !abort_sent && !phase_done;
        case (state)
            IDLE:    if (go_arb) state_nx = ARB;
            ARB:     state_nx = arb_found ? OFFER : IDLE;
            OFFER:   if (grant_ready) state_nx = ACTIVE;
            ACTIVE:  if (phase_done) state_nx = go_arb ? ARB : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt         <= '0;
            pending      <= '0;
            preempt_pend <= 1'b0;
            preempt_id   <= 2'd0;
            last_granted <= 2'd3;
            grant_phase  <= 2'd0;
            grant_pre    <= 1'b0;
            abort        <= 1'b0;
            abort_sent   <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                db_cnt[n] <= '0;
                age[n]    <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (raw[n] != filt[n]) begin
                    if (db_cnt[n] == CW'(DEBOUNCE - 1)) begin
                        filt[n]   <= raw[n];
                        db_cnt[n] <= '0;
                    end else begin
                        db_cnt[n] <= db_cnt[n] + CW'(1);
                    end
                end else begin
                    db_cnt[n] <= '0;
                end

                if (accept && (grant_phase == 2'(n))) begin
                    pending[n] <= 1'b0;
                    age[n]     <= '0;
                end else begin
                    pending[n] <= pending[n] | filt[n];
                    if (!pending[n]) begin
                        age[n] <= '0;
                    end else if (!(in_grant && (grant_phase == 2'(n))) && (age[n] != 8'hFF)) begin
                        age[n] <= age[n] + 8'd1;
                    end
                end
            end

            // A fresh preempt request always overrides any clearing on the same edge.
            if (preempt) begin
                preempt_pend <= 1'b1;
                preempt_id   <= preempt_phase;
            end else if (accept && grant_pre && (preempt_id == grant_phase)) begin
                preempt_pend <= 1'b0;
            end else if ((state == ACTIVE) && preempt_pend && (preempt_id == grant_phase)) begin
                preempt_pend <= 1'b0;
            end

            if ((state == ARB) && arb_found) begin
                grant_phase <= arb_phase;
                grant_pre   <= arb_pre;
            end

            abort <= abort_nx;
            if (accept) begin
                last_granted <= grant_phase;
                abort_sent   <= 1'b0;
            end else if (abort_nx) begin
                abort_sent <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios with literal expectations plus a
// randomized run, all checked each cycle against a behavioural model of the scheduler.
module tb_traffic_phase_scheduler;
    localparam int DEB = 3;
    localparam int STV = 20;
    localparam int M_IDLE   = 0;
    localparam int M_ARB    = 1;
    localparam int M_OFFER  = 2;
    localparam int M_ACTIVE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw = 4'b0;
    logic       preempt = 1'b0;
    logic [1:0] preempt_phase = 2'd0;
    logic       grant_ready = 1'b0;
    logic       phase_done = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_phase;
    logic       abort;
    logic [3:0] pending;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int m_filt [4];
    int m_cnt [4];
    int m_pend [4];
    int m_age [4];
    int m_mode, m_gph, m_last, m_pid;
    int m_ppend, m_gpre, m_aborted, m_abort;

    int grants[$];
    bit auto_done = 1'b0;
    int done_delay = 3;
    bit ctl_active = 1'b0;
    int ctl_cnt = 0;

    traffic_phase_scheduler #(.DEBOUNCE(DEB), .STARVE_MAX(STV)) dut (
        .clk           (clk),
        .reset         (reset),
        .ew_str_sensor (raw[0]),
        .ew_left_sensor(raw[1]),
        .ns_sensor     (raw[2]),
        .ped_button    (raw[3]),
        .preempt       (preempt),
        .preempt_phase (preempt_phase),
        .grant_valid   (grant_valid),
        .grant_phase   (grant_phase),
        .grant_ready   (grant_ready),
        .phase_done    (phase_done),
        .abort         (abort),
        .pending       (pending),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_filt[n] = 0; m_cnt[n] = 0; m_pend[n] = 0; m_age[n] = 0;
        end
        m_mode = M_IDLE; m_gph = 0; m_last = 3; m_pid = 0;
        m_ppend = 0; m_gpre = 0; m_aborted = 0; m_abort = 0;
    endtask

    // One clock edge of the scheduler's rules, evaluated on the inputs present at that edge.
    task automatic model_step();
        int n_pend [4];
        int n_age [4];
        int pick, pre, acc, any, s, idx;
        int n_mode, n_gph, n_gpre, n_last, n_ppend, n_pid, n_aborted, n_abort;
        acc = (m_mode == M_OFFER && grant_ready) ? 1 : 0;
        any = ((m_pend[0] + m_pend[1] + m_pend[2] + m_pend[3]) > 0 || m_ppend != 0) ? 1 : 0;
        for (int n = 0; n < 4; n++) begin
            if (acc != 0 && m_gph == n) begin
                n_pend[n] = 0;
                n_age[n] = 0;
            end else begin
                n_pend[n] = (m_pend[n] != 0 || m_filt[n] != 0) ? 1 : 0;
                if (m_pend[n] == 0) n_age[n] = 0;
                else if ((m_mode == M_OFFER || m_mode == M_ACTIVE) && m_gph == n) n_age[n] = m_age[n];
                else n_age[n] = (m_age[n] >= 255) ? 255 : m_age[n] + 1;
            end
        end
        for (int n = 0; n < 4; n++) begin
            if (int'(raw[n]) != m_filt[n]) begin
                m_cnt[n]++;
                if (m_cnt[n] == DEB) begin
                    m_filt[n] = int'(raw[n]);
                    m_cnt[n] = 0;
                end
            end else begin
                m_cnt[n] = 0;
            end
        end
        pick = -1; pre = 0;
        if (m_ppend != 0) begin
            pick = m_pid; pre = 1;
        end else begin
            for (int n = 0; n < 4; n++)
                if (pick < 0 && m_pend[n] != 0 && m_age[n] >= STV) pick = n;
            for (s = 1; s <= 4; s++) begin
                idx = (m_last + s) % 4;
                if (pick < 0 && m_pend[idx] != 0) pick = idx;
            end
        end
        n_mode = m_mode; n_gph = m_gph; n_gpre = m_gpre; n_last = m_last; n_aborted = m_aborted;
        n_abort = (m_mode == M_ACTIVE && m_ppend != 0 && m_pid != m_gph && m_aborted == 0
                   && !phase_done) ? 1 : 0;
        if (n_abort != 0) n_aborted = 1;
        case (m_mode)
            M_IDLE:  if (any != 0) n_mode = M_ARB;
            M_ARB:   if (pick >= 0) begin n_mode = M_OFFER; n_gph = pick; n_gpre = pre; end
                     else n_mode = M_IDLE;
            M_OFFER: if (acc != 0) begin n_mode = M_ACTIVE; n_last = m_gph; n_aborted = 0; end
            default: if (phase_done) n_mode = (any != 0) ? M_ARB : M_IDLE;
        endcase
        n_ppend = m_ppend; n_pid = m_pid;
        if (preempt) begin
            n_ppend = 1; n_pid = int'(preempt_phase);
        end else if (acc != 0 && m_gpre != 0 && m_pid == m_gph) begin
            n_ppend = 0;
        end else if (m_mode == M_ACTIVE && m_ppend != 0 && m_pid == m_gph) begin
            n_ppend = 0;
        end
        for (int n = 0; n < 4; n++) begin
            m_pend[n] = n_pend[n]; m_age[n] = n_age[n];
        end
        m_mode = n_mode; m_gph = n_gph; m_gpre = n_gpre; m_last = n_last;
        m_aborted = n_aborted; m_abort = n_abort; m_ppend = n_ppend; m_pid = n_pid;
    endtask

    task automatic compare();
        chk("grant_valid", int'(grant_valid), (m_mode == M_OFFER) ? 1 : 0);
        chk("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        chk("grant_phase", int'(grant_phase), m_gph);
        chk("abort", int'(abort), m_abort);
        chk("pending", int'(pending), m_pend[0] + 2 * m_pend[1] + 4 * m_pend[2] + 8 * m_pend[3]);
    endtask

    // Called at a falling edge; applies one rising edge, checks, returns at the next falling edge.
    task automatic cyc();
        bit acc_now;
        int acc_ph;
        if (auto_done) phase_done = ctl_active && (ctl_cnt == done_delay);
        acc_now = grant_valid && grant_ready;
        acc_ph = int'(grant_phase);
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (acc_now) begin
            grants.push_back(acc_ph);
            ctl_active = 1'b1;
            ctl_cnt = 1;
        end else if (ctl_active) begin
            if (phase_done) ctl_active = 1'b0;
            else ctl_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        raw = 4'b0; preempt = 1'b0; preempt_phase = 2'd0;
        grant_ready = 1'b0; phase_done = 1'b0;
        auto_done = 1'b0; ctl_active = 1'b0; ctl_cnt = 0;
        grants.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_grants(input int n, input int limit, input string name);
        int k = 0;
        while (grants.size() < n && k < limit) begin
            cyc();
            k++;
        end
        chk(name, (grants.size() >= n) ? 1 : 0, 1);
    endtask

    function automatic int grant_at(input int i);
        return (grants.size() > i) ? grants[i] : -1;
    endfunction

    initial begin
        int exp_order [5];
        int pat [6];
        int abort_cnt;
        int stable;
        int k;

        // Reset state
        do_reset();
        chk("reset_grant_valid", int'(grant_valid), 0);
        chk("reset_grant_phase", int'(grant_phase), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_abort", int'(abort), 0);

        // End-to-end latency from a held ns_sensor
        raw[2] = 1'b1; grant_ready = 1'b1;
        repeat (4) cyc();
        chk("lat_busy_e4", int'(busy), 0);
        cyc();
        chk("lat_busy_e5", int'(busy), 1);
        chk("lat_gv_e5", int'(grant_valid), 0);
        cyc();
        chk("lat_gv_e6", int'(grant_valid), 1);
        chk("lat_phase_e6", int'(grant_phase), 2);

        // Glitchy sensor never passes the filter
        do_reset();
        pat = '{1, 1, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            raw[2] = pat[i][0];
            cyc();
            chk("glitch_pending", int'(pending), 0);
            chk("glitch_gv", int'(grant_valid), 0);
        end
        raw[2] = 1'b0;
        repeat (5) cyc();
        chk("glitch_pending_end", int'(pending), 0);

        // Round-robin with all sensors held
        do_reset();
        raw = 4'hF; grant_ready = 1'b1; auto_done = 1'b1; done_delay = 3;
        wait_grants(5, 120, "rr_timeout");
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) chk("rr_order", grant_at(i), exp_order[i]);

        // Preemption during phase 2 aborts once, then preempt phase wins over older pending[1]
        do_reset();
        raw[2] = 1'b1; grant_ready = 1'b1; auto_done = 1'b1; done_delay = 12;
        wait_grants(1, 30, "pre_first_timeout");
        chk("pre_first_phase", grant_at(0), 2);
        raw[2] = 1'b0; raw[1] = 1'b1;
        cyc(); cyc();
        preempt = 1'b1; preempt_phase = 2'd0;
        abort_cnt = 0;
        k = 0;
        while (grants.size() < 2 && k < 40) begin
            cyc();
            preempt = 1'b0;
            abort_cnt += int'(abort);
            k++;
        end
        chk("pre_abort_count", abort_cnt, 1);
        chk("pre_next_phase", grant_at(1), 0);

        // phase_done together with preempt: no abort, next grant is the preempt phase
        do_reset();
        raw[2] = 1'b1; grant_ready = 1'b1;
        wait_grants(1, 30, "pd_first_timeout");
        raw[2] = 1'b0; grant_ready = 1'b0;
        cyc(); cyc();
        phase_done = 1'b1; preempt = 1'b1; preempt_phase = 2'd1;
        cyc();
        abort_cnt = int'(abort);
        phase_done = 1'b0; preempt = 1'b0; grant_ready = 1'b1;
        k = 0;
        while (grants.size() < 2 && k < 20) begin
            cyc();
            abort_cnt += int'(abort);
            k++;
        end
        chk("pd_abort_count", abort_cnt, 0);
        chk("pd_next_phase", grant_at(1), 1);

        // Long-held offer: phase stays, ages saturate, starved lowest index beats round-robin
        do_reset();
        raw[2] = 1'b1;
        k = 0;
        while (!grant_valid && k < 20) begin cyc(); k++; end
        chk("hold_offer_seen", int'(grant_valid), 1);
        raw[2] = 1'b0; raw[1] = 1'b1; raw[3] = 1'b1;
        stable = 1;
        for (int i = 0; i < 262; i++) begin
            cyc();
            if (!grant_valid || grant_phase != 2'd2) stable = 0;
        end
        chk("hold_stable", stable, 1);
        grant_ready = 1'b1; auto_done = 1'b1; done_delay = 2;
        wait_grants(2, 30, "hold_timeout");
        chk("hold_first", grant_at(0), 2);
        chk("hold_starved_pick", grant_at(1), 1);

        // Asynchronous reset in the middle of an offer
        do_reset();
        raw[2] = 1'b1;
        k = 0;
        while (!grant_valid && k < 20) begin cyc(); k++; end
        chk("rst_offer_seen", int'(grant_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_gv", int'(grant_valid), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_busy", int'(busy), 0);
        model_reset();
        raw = 4'b0; grant_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) cyc();
        chk("rst_idle_busy", int'(busy), 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 4; n++)
                if ($urandom_range(0, 7) == 0) raw[n] = ~raw[n];
            preempt = ($urandom_range(0, 29) == 0);
            preempt_phase = 2'($urandom_range(0, 3));
            grant_ready = 1'($urandom_range(0, 1));
            phase_done = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
